// File: rtl/lsu_initiator.sv
// Load/store initiator: issues one aligned bus access per request, waits out the
// responder's read latency, then returns an extended load result or a store completion.
module lsu_initiator #(
    parameter int unsigned MEM_READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_enable,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned CntW = (MEM_READ_LATENCY > 1) ? $clog2(MEM_READ_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e         state_q;
    logic [31:0]    addr_q;
    logic [2:0]     funct3_q;
    logic           is_store_q;
    logic [31:0]    wdata_q;
    logic [3:0]     we_q;
    logic [CntW-1:0] cnt_q;
    logic           ready_q;
    logic           resp_valid_q;
    logic [31:0]    resp_rdata_q;
    logic           resp_fault_q;

    logic           req_fault;
    logic [3:0]     store_we;
    logic [31:0]    store_data;
    logic [31:0]    shifted;
    logic [31:0]    load_data;

    always_comb begin
        req_fault = 1'b0;
        if (req_is_store) begin
            req_fault = (req_funct3 > 3'd2);
        end else begin
            req_fault = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
        end
        if (req_funct3[1:0] == 2'd1 && req_addr[0]) begin
            req_fault = 1'b1;
        end
        if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00) begin
            req_fault = 1'b1;
        end
    end

    // Store data is replicated across lanes so the strobes alone select the bytes.
    always_comb begin
        store_we   = 4'b0000;
        store_data = req_wdata;
        case (req_funct3[1:0])
            2'd0: begin
                store_we   = 4'b0001 << req_addr[1:0];
                store_data = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                store_we   = req_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{req_wdata[15:0]}};
            end
            2'd2: store_we = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        shifted   = mem_read_data >> {addr_q[1:0], 3'b000};
        load_data = 32'h0;
        case (funct3_q)
            3'd0: load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'd1: load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'd2: load_data = shifted;
            3'd4: load_data = {24'h0, shifted[7:0]};
            3'd5: load_data = {16'h0, shifted[15:0]};
            default: load_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            addr_q       <= 32'h0;
            funct3_q     <= 3'd0;
            is_store_q   <= 1'b0;
            wdata_q      <= 32'h0;
            we_q         <= 4'b0000;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            we_q         <= 4'b0000;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        funct3_q   <= req_funct3;
                        is_store_q <= req_is_store;
                        ready_q    <= 1'b0;
                        if (req_fault) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q <= StIssue;
                            if (req_is_store) begin
                                wdata_q <= store_data;
                                we_q    <= store_we;
                            end
                        end
                    end
                end
                StIssue: begin
                    if (is_store_q) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b0;
                        resp_rdata_q <= 32'h0;
                    end else begin
                        cnt_q   <= CntW'(MEM_READ_LATENCY - 1);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b0;
                        resp_rdata_q <= load_data;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    state_q      <= StIdle;
                    ready_q      <= 1'b1;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready        = ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_fault       = resp_fault_q;
    assign mem_address      = {addr_q[31:2], 2'b00};
    assign mem_write_data   = wdata_q;
    // Gated by reset so a store caught mid-issue never reaches the bus.
    assign mem_write_enable = we_q & {4{reset_n}};

endmodule

// File: tb/tb_lsu_initiator.sv
// Bench for lsu_initiator: byte-lane RAM plus LEDR responder model and an expected-response queue.
module tb_lsu_initiator;

    localparam int unsigned LAT = 1;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_enable;
    logic [31:0] mem_read_data;

    int vectors = 0;
    int miscompares = 0;

    lsu_initiator #(.MEM_READ_LATENCY(LAT)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_store     (req_is_store),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_fault       (resp_fault),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: four byte lanes of RAM, LEDR at 0x10000000, registered read of LAT cycles.
    logic [31:0] ram [0:255];
    logic [31:0] ledr_word;
    logic        preload_en;
    logic [31:0] rd_pipe [LAT];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (preload_en) begin
            ram[16] <= 32'h876543F1;
        end else if (mem_write_enable != 4'b0000) begin
            if (mem_address == 32'h1000_0000)
                ledr_word <= merge(ledr_word, mem_write_data, mem_write_enable) & 32'h3FF;
            else
                ram[mem_address[9:2]] <= merge(ram[mem_address[9:2]], mem_write_data,
                                               mem_write_enable);
        end
        rd_pipe[0] <= (mem_address == 32'h1000_0000) ? ledr_word : ram[mem_address[9:2]];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_read_data = rd_pipe[LAT-1];

    typedef struct {
        logic [31:0] rd; logic fault; int lat; logic [3:0] we; logic [31:0] wd; logic [31:0] maddr;
    } exp_t;
    typedef struct {
        logic st; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd;
        logic [31:0] rd; logic fault; logic [3:0] we; logic [31:0] ewd;
    } vec_t;
    typedef struct {
        logic ready; logic got; int lat; logic [31:0] rd; logic fault;
        int we_cnt; logic [3:0] we; logic [31:0] wd; logic [31:0] maddr; logic after_valid;
    } obs_t;

    exp_t sb_q[$];

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd, input logic fault,
                                input logic [3:0] we, input logic [31:0] ewd);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.rd = rd; v.fault = fault; v.we = we; v.ewd = ewd;
        return v;
    endfunction

    // Drives one request, queues what should come back, and records what the DUT did.
    task automatic run_req(input vec_t v, output obs_t o);
        exp_t e;
        o.ready = 1'b0; o.got = 1'b0; o.lat = 0; o.rd = 32'h0; o.fault = 1'b0;
        o.we_cnt = 0; o.we = 4'b0; o.wd = 32'h0; o.maddr = 32'h0; o.after_valid = 1'b0;
        for (int w = 0; w < 10 && !o.ready; w++) begin
            @(negedge clk);
            o.ready = req_ready;
        end
        req_valid = 1'b1; req_is_store = v.st; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wd;
        e.rd = v.rd; e.fault = v.fault; e.we = v.we; e.wd = v.ewd;
        e.lat = v.fault ? 1 : (v.st ? 2 : 2 + int'(LAT));
        e.maddr = {v.addr[31:2], 2'b00};
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (mem_write_enable !== 4'b0000) begin
                o.we_cnt++; o.we = mem_write_enable; o.wd = mem_write_data; o.maddr = mem_address;
            end
            if (resp_valid === 1'b1) begin
                o.got = 1'b1; o.lat = c; o.rd = resp_rdata; o.fault = resp_fault;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        o.after_valid = resp_valid;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        preload_en = 1'b0;
        vectors++; if (req_ready !== 1'b1) begin miscompares++;
            $display("FAIL reset req_ready: got %b expected 1", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++;
            $display("FAIL reset resp_valid: got %b expected 0", resp_valid); end
        vectors++; if (resp_rdata !== 32'h0) begin miscompares++;
            $display("FAIL reset resp_rdata: got %h expected 0", resp_rdata); end
        vectors++; if (resp_fault !== 1'b0) begin miscompares++;
            $display("FAIL reset resp_fault: got %b expected 0", resp_fault); end
        vectors++; if (mem_address !== 32'h0) begin miscompares++;
            $display("FAIL reset mem_address: got %h expected 0", mem_address); end
        vectors++; if (mem_write_data !== 32'h0) begin miscompares++;
            $display("FAIL reset mem_write_data: got %h expected 0", mem_write_data); end
        vectors++; if (mem_write_enable !== 4'b0) begin miscompares++;
            $display("FAIL reset mem_write_enable: got %b expected 0", mem_write_enable); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load;
        vec_t t[$]; obs_t o; exp_t e;
        t.push_back(mk(1'b0, 3'd0, 32'h40, 32'h0, 32'hFFFFFFF1, 1'b0, 4'b0, 32'h0));
        t.push_back(mk(1'b0, 3'd4, 32'h40, 32'h0, 32'h000000F1, 1'b0, 4'b0, 32'h0));
        t.push_back(mk(1'b0, 3'd0, 32'h41, 32'h0, 32'h00000043, 1'b0, 4'b0, 32'h0));
        t.push_back(mk(1'b0, 3'd0, 32'h43, 32'h0, 32'hFFFFFF87, 1'b0, 4'b0, 32'h0));
        t.push_back(mk(1'b0, 3'd1, 32'h42, 32'h0, 32'hFFFF8765, 1'b0, 4'b0, 32'h0));
        t.push_back(mk(1'b0, 3'd5, 32'h42, 32'h0, 32'h00008765, 1'b0, 4'b0, 32'h0));
        t.push_back(mk(1'b0, 3'd2, 32'h40, 32'h0, 32'h876543F1, 1'b0, 4'b0, 32'h0));
        foreach (t[k]) begin
            run_req(t[k], o);
            e = sb_q.pop_front();
            vectors++; if (o.ready !== 1'b1 || o.got !== 1'b1 || o.lat != e.lat) begin
                miscompares++;
                $display("FAIL load[%0d] timing: got ready=%b valid=%b after %0d, expected 1 1 %0d",
                         k, o.ready, o.got, o.lat, e.lat); end
            vectors++; if (o.rd !== e.rd) begin miscompares++;
                $display("FAIL load[%0d] rdata: got %h expected %h", k, o.rd, e.rd); end
            vectors++; if (o.fault !== e.fault) begin miscompares++;
                $display("FAIL load[%0d] fault: got %b expected %b", k, o.fault, e.fault); end
            vectors++; if (o.we_cnt != 0 || o.after_valid !== 1'b0) begin miscompares++;
                $display("FAIL load[%0d] we/pulse: got we_cycles=%0d valid_after=%b expected 0 0",
                         k, o.we_cnt, o.after_valid); end
        end
    endtask

    task automatic test_store;
        vec_t t[$]; obs_t o; exp_t e;
        t.push_back(mk(1'b1, 3'd0, 32'h43, 32'h000000AA, 32'h0, 1'b0, 4'b1000, 32'hAAAAAAAA));
        t.push_back(mk(1'b0, 3'd2, 32'h40, 32'h0, 32'hAA6543F1, 1'b0, 4'b0, 32'h0));
        t.push_back(mk(1'b1, 3'd1, 32'h42, 32'h00001234, 32'h0, 1'b0, 4'b1100, 32'h12341234));
        t.push_back(mk(1'b0, 3'd1, 32'h42, 32'h0, 32'h00001234, 1'b0, 4'b0, 32'h0));
        t.push_back(mk(1'b1, 3'd2, 32'h1000_0000, 32'h3FF, 32'h0, 1'b0, 4'b1111, 32'h3FF));
        t.push_back(mk(1'b0, 3'd2, 32'h1000_0000, 32'h0, 32'h3FF, 1'b0, 4'b0, 32'h0));
        foreach (t[k]) begin
            run_req(t[k], o);
            e = sb_q.pop_front();
            vectors++; if (o.got !== 1'b1 || o.lat != e.lat) begin miscompares++;
                $display("FAIL store[%0d] latency: got valid=%b after %0d, expected %0d",
                         k, o.got, o.lat, e.lat); end
            vectors++; if (o.rd !== e.rd || o.fault !== e.fault) begin miscompares++;
                $display("FAIL store[%0d] resp: got %h/%b expected %h/%b",
                         k, o.rd, o.fault, e.rd, e.fault); end
            vectors++; if (o.we_cnt != ((e.we != 4'b0) ? 1 : 0)) begin miscompares++;
                $display("FAIL store[%0d] we cycles: got %0d expected %0d",
                         k, o.we_cnt, (e.we != 4'b0) ? 1 : 0); end
            if (e.we != 4'b0) begin
                vectors++; if (o.we !== e.we || o.wd !== e.wd || o.maddr !== e.maddr) begin
                    miscompares++;
                    $display("FAIL store[%0d] bus: got we=%b wd=%h addr=%h expected %b %h %h",
                             k, o.we, o.wd, o.maddr, e.we, e.wd, e.maddr); end
            end
        end
        vectors++; if (ledr_word !== 32'h3FF) begin miscompares++;
            $display("FAIL store ledr: got %h expected 000003ff", ledr_word); end
    endtask

    task automatic test_fault;
        vec_t t[$]; obs_t o; exp_t e;
        t.push_back(mk(1'b0, 3'd2, 32'h42, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0));
        t.push_back(mk(1'b1, 3'd1, 32'h41, 32'h5555, 32'h0, 1'b1, 4'b0, 32'h0));
        t.push_back(mk(1'b0, 3'd3, 32'h40, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0));
        t.push_back(mk(1'b0, 3'd6, 32'h40, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0));
        t.push_back(mk(1'b1, 3'd4, 32'h40, 32'h77, 32'h0, 1'b1, 4'b0, 32'h0));
        t.push_back(mk(1'b0, 3'd5, 32'h43, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0));
        foreach (t[k]) begin
            run_req(t[k], o);
            e = sb_q.pop_front();
            vectors++; if (o.got !== 1'b1 || o.lat != e.lat) begin miscompares++;
                $display("FAIL fault[%0d] latency: got valid=%b after %0d, expected %0d",
                         k, o.got, o.lat, e.lat); end
            vectors++; if (o.fault !== e.fault || o.rd !== e.rd) begin miscompares++;
                $display("FAIL fault[%0d] resp: got fault=%b rdata=%h expected %b %h",
                         k, o.fault, o.rd, e.fault, e.rd); end
            vectors++; if (o.we_cnt != 0) begin miscompares++;
                $display("FAIL fault[%0d] we cycles: got %0d expected 0", k, o.we_cnt); end
        end
    endtask

    task automatic test_reset_mid_issue;
        int late_valid;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if (mem_write_enable !== 4'b1111) begin miscompares++;
            $display("FAIL midreset issue we: got %b expected 1111", mem_write_enable); end
        reset_n = 1'b0;
        #1;
        vectors++; if (mem_write_enable !== 4'b0000) begin miscompares++;
            $display("FAIL midreset gated we: got %b expected 0000", mem_write_enable); end
        @(negedge clk);
        reset_n = 1'b1;
        vectors++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin miscompares++;
            $display("FAIL midreset after: got ready=%b valid=%b expected 1 0",
                     req_ready, resp_valid); end
        late_valid = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid === 1'b1) late_valid++;
        end
        vectors++; if (late_valid != 0) begin miscompares++;
            $display("FAIL midreset resp_valid: got %0d pulses expected 0", late_valid); end
        vectors++; if (ram[16] !== 32'h123443F1) begin miscompares++;
            $display("FAIL midreset memory: got %h expected 123443f1", ram[16]); end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; preload_en = 1'b1;
        test_reset;
        test_load;
        test_store;
        test_fault;
        test_reset_mid_issue;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_initiator.md
Name: lsu_initiator

Overview:
- Load/store initiator for the core's datapath side of the memory-mapped bus; the bus responder holds four byte-lane RAMs plus the LEDR register at 0x10000000.
- Accepts one load or store request at a time and drives word-aligned address, lane-replicated write data and a 4-bit byte write-enable.
- Waits out the responder's registered read latency, then returns a sign- or zero-extended load result or a store completion.
- Flags misaligned accesses and unsupported funct3 values as faults, with no bus access.

Parameters:
- MEM_READ_LATENCY, 1, cycles from address driven to valid mem_read_data; must be >= 1.

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  synchronous reset, active-low
- req_valid  input  1  request present
- req_ready  output  1  request can be accepted
- req_is_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I width code: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2
- req_addr  input  32  byte address (addr_t)
- req_wdata  input  32  store data, right-aligned (data_t)
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  load result, valid with resp_valid
- resp_fault  output  1  misaligned or invalid funct3, valid with resp_valid
- mem_address  output  32  bus address, always word-aligned {addr[31:2],2'b00}
- mem_write_data  output  32  bus write data
- mem_write_enable  output  4  byte-lane write strobes
- mem_read_data  input  32  bus read data

Behaviour:
- Reset (reset_n low at an edge):
  - state becomes IDLE; internal addr, funct3, data and wait counter clear to 0.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_address=0, mem_write_data=0, mem_write_enable=0.
  - mem_write_enable is combinationally gated by reset_n, so no write is issued in any cycle where reset_n=0, including a store mid-ISSUE.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, latch the request.
  - Valid and aligned request -> ISSUE. Fault -> RESP with fault=1.
- Fault conditions:
  - Load funct3 in {3,6,7}, or store funct3 > 2.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
- ISSUE (exactly 1 cycle), mem_address driven from the latched address:
  - Store:
    - mem_write_enable asserted this cycle only.
    - SB: write_data={4{wdata[7:0]}}, we=4'b0001<<addr[1:0].
    - SH: write_data={2{wdata[15:0]}}, we = addr[1] ? 4'b1100 : 4'b0011.
    - SW: write_data=wdata, we=4'b1111.
    - Next state RESP.
  - Load: we=0; counter loaded with MEM_READ_LATENCY-1; next state WAIT.
- WAIT:
  - mem_address held and we=0.
  - Counter counts down each cycle.
  - When counter==0, capture mem_read_data at this edge and go to RESP.
  - Extraction: shift right by 8*addr[1:0]. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW unmodified.
- RESP:
  - resp_valid=1 for exactly one cycle; then IDLE.
  - resp_rdata = extracted value for a load, 0 for a store or fault.
  - req_ready=0 in all states except IDLE. No response backpressure.
- Latency (request accepted at edge E0):
  - Store: write commits at edge E1; resp_valid in cycle after E1.
  - Load: resp_valid in cycle E0+2+MEM_READ_LATENCY (=3 cycles after acceptance at default).
  - Fault: resp_valid in cycle after E0.
- mem_address remains at the last latched address in IDLE/RESP; only we qualifies a write.
- Byte store to LEDR writes write_data[9:0] via lane replication; no special case.
- req_* inputs are ignored outside IDLE.

Test Plan:
- Preload word 0x40 = 0x876543F1.
  - LB 0x40 -> 0xFFFFFFF1; LBU 0x40 -> 0x000000F1; LB 0x41 -> 0x00000043.
  - Each response arrives 3 cycles after acceptance with resp_fault=0.
- Same preload:
  - LH 0x42 -> 0xFFFF8765; LHU 0x42 -> 0x00008765; LW 0x40 -> 0x876543F1.
- SB addr 0x43, wdata 0x000000AA:
  - One cycle with mem_address=0x40, mem_write_data=0xAAAAAAAA, we=4'b1000.
  - Following LW 0x40 -> 0xAA6543F1.
- LW 0x42 and SH 0x41:
  - resp_fault=1 and resp_rdata=0 one cycle after acceptance.
  - we stays 0 throughout.
  - Invalid funct3 (load funct3=3) gives the same fault result.
- SW 0x10000000, wdata 0x000003FF:
  - LEDR becomes 0x3FF.
  - LW 0x10000000 -> 0x000003FF.
- SW 0x40 with reset_n driven low during the ISSUE cycle:
  - mem_write_enable=0 in that cycle; memory word unchanged.
  - No resp_valid; req_ready=1 the cycle after reset.
